// File: rtl/DPE_params.sv
// Shared scan-frame geometry and loader state encoding for the DPE scan path.
package DPE_params;

    localparam int SRAM_WORD_LENGTH = 32;
    localparam int SRAM_ADDR_WIDTH  = 8;

    // Data slots + address slots + marker slot + commit slot.
    localparam int SCAN_FRAME_LEN   = SRAM_WORD_LENGTH + SRAM_ADDR_WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_DATA,
        SHIFT_ADDR,
        MARK,
        COMMIT,
        FINAL
    } scan_state_t;

endpackage

// File: rtl/sc_clk_gen.sv
// Free-running scan clock generator. o_sc_clk is a registered square wave of
// period 2*CLKS_PER_HALF_SC system clocks. o_strike is high for exactly one
// cycle: the cycle whose closing CLK edge drives o_sc_clk low, so logic that
// updates on o_strike changes in lockstep with the SC_CLK falling edge.
module sc_clk_gen #(
    parameter int CLKS_PER_HALF_SC = 2
) (
    input  logic CLK,
    input  logic RESET,
    output logic o_sc_clk,
    output logic o_strike
);

    localparam int            CW        = (CLKS_PER_HALF_SC > 1) ? $clog2(CLKS_PER_HALF_SC) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_HALF_SC - 1);

    logic [CW-1:0] r_cnt;
    logic          r_sc_clk;
    logic          w_half_end;

    assign w_half_end = (r_cnt == HALF_LAST);

    // Half-period counter; toggle the scan clock at the end of every half period.
    always_ff @(posedge CLK) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // pre-edge values, independent of statement order between blocks.
        if (RESET) begin
            r_cnt    <= '0;
            r_sc_clk <= 1'b0;
        end else if (w_half_end) begin
            r_cnt    <= '0;
            r_sc_clk <= ~r_sc_clk;
        end else begin
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    assign o_sc_clk = r_sc_clk;
    assign o_strike = w_half_end & r_sc_clk;

endmodule

// File: rtl/scan_loader.sv
// Serialises SRAM init requests onto the DPE scan chain. Each frame shifts the
// word then the address LSB-first, a marker 1, then a commit slot with SC_EN
// low. An end-of-init request shifts all ones and parks in FINAL with SC_EN low.
module scan_loader #(
    parameter int SRAM_WORD_LENGTH = DPE_params::SRAM_WORD_LENGTH,
    parameter int SRAM_ADDR_WIDTH  = DPE_params::SRAM_ADDR_WIDTH,
    parameter int CLKS_PER_HALF_SC = 2
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [SRAM_WORD_LENGTH-1:0] i_word,
    input  logic [SRAM_ADDR_WIDTH-1:0]  i_addr,
    input  logic                        i_last,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic                        o_SC_CLK,
    output logic                        o_SC_EN,
    output logic                        o_scanIn,
    output logic                        o_busy,
    output logic                        o_done
);

    import DPE_params::*;

    localparam int               CNT_W     = $clog2(SRAM_WORD_LENGTH + SRAM_ADDR_WIDTH + 2);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(SRAM_WORD_LENGTH - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(SRAM_ADDR_WIDTH - 1);

    scan_state_t                 r_state;
    logic [CNT_W-1:0]            r_cnt;
    logic [SRAM_WORD_LENGTH-1:0] r_word;
    logic [SRAM_ADDR_WIDTH-1:0]  r_addr;
    logic                        r_last;
    logic                        r_pend;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_sc_en;
    logic                        r_scan_in;

    logic                        w_sc_clk;
    logic                        w_strike;
    logic                        w_commit_end;
    logic                        w_accept;
    logic                        w_start;
    logic [SRAM_WORD_LENGTH-1:0] w_word;
    logic [SRAM_ADDR_WIDTH-1:0]  w_addr;
    logic                        w_last;

    sc_clk_gen #(
        .CLKS_PER_HALF_SC (CLKS_PER_HALF_SC)
    ) u_sc_clk_gen (
        .CLK      (CLK),
        .RESET    (RESET),
        .o_sc_clk (w_sc_clk),
        .o_strike (w_strike)
    );

    // Busy drops in the last cycle of the commit slot so a request accepted
    // there starts at the very falling edge that ends the commit slot.
    assign w_commit_end = (r_state == COMMIT) && w_strike;
    assign o_busy       = r_busy && !w_commit_end;
    assign o_ready      = !RESET && !o_busy && !r_done;
    assign w_accept     = i_valid && o_ready;
    assign w_start      = w_accept || r_pend;

    // Frame source: a request accepted this cycle wins over a parked one.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_word = r_word;
        w_addr = r_addr;
        w_last = r_last;
        if (w_accept) begin
            w_word = i_last ? '1 : i_word;
            w_addr = i_last ? '1 : i_addr;
            w_last = i_last;
        end
    end

    // Loader FSM: capture requests, advance one slot per SC_CLK falling edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_word    <= '0;
            r_addr    <= '0;
            r_last    <= 1'b0;
            r_pend    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sc_en   <= 1'b1;
            r_scan_in <= 1'b0;
        end else begin
            // Park an accepted request until the next falling edge.
            if (w_accept) begin
                r_busy <= 1'b1;
                r_pend <= 1'b1;
                r_word <= w_word;
                r_addr <= w_addr;
                r_last <= w_last;
            end

            if (w_strike) begin
                case (r_state)
                    IDLE: begin
                        r_sc_en <= 1'b1;
                        if (w_start) begin
                            r_state   <= SHIFT_DATA;
                            r_cnt     <= DATA_LAST;
                            r_scan_in <= w_word[0];
                            r_word    <= w_word >> 1;
                            r_addr    <= w_addr;
                            r_last    <= w_last;
                            r_pend    <= 1'b0;
                        end
                    end

                    SHIFT_DATA: begin
                        if (r_cnt == '0) begin
                            r_state   <= SHIFT_ADDR;
                            r_cnt     <= ADDR_LAST;
                            r_scan_in <= r_addr[0];
                            r_addr    <= r_addr >> 1;
                        end else begin
                            r_cnt     <= r_cnt - CNT_W'(1);
                            r_scan_in <= r_word[0];
                            r_word    <= r_word >> 1;
                        end
                    end

                    SHIFT_ADDR: begin
                        if (r_cnt == '0) begin
                            r_scan_in <= 1'b1;
                            if (r_last) begin
                                r_state <= FINAL;
                                r_sc_en <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= MARK;
                            end
                        end else begin
                            r_cnt     <= r_cnt - CNT_W'(1);
                            r_scan_in <= r_addr[0];
                            r_addr    <= r_addr >> 1;
                        end
                    end

                    MARK: begin
                        r_state   <= COMMIT;
                        r_scan_in <= 1'b1;
                        r_sc_en   <= 1'b0;
                    end

                    COMMIT: begin
                        r_sc_en <= 1'b1;
                        if (w_accept) begin
                            r_state   <= SHIFT_DATA;
                            r_cnt     <= DATA_LAST;
                            r_scan_in <= w_word[0];
                            r_word    <= w_word >> 1;
                            r_pend    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end

                    FINAL: begin
                        r_scan_in <= 1'b1;
                        r_sc_en   <= 1'b0;
                    end

                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_SC_CLK = w_sc_clk;
    assign o_SC_EN  = r_sc_en;
    assign o_scanIn = r_scan_in;
    assign o_done   = r_done;

endmodule

// File: tb/tb_scan_loader.sv
// Bench for scan_loader: a behavioural DPE receiver shifts o_scanIn on every
// SC_CLK rising edge with SC_EN high and decodes a frame when SC_EN goes low;
// decoded frames are compared with the requests the bench issued.
module tb_scan_loader;

    localparam int W   = DPE_params::SRAM_WORD_LENGTH;
    localparam int A   = DPE_params::SRAM_ADDR_WIDTH;
    localparam int CPH = 2;
    localparam int FL  = W + A + 1;

    logic         CLK     = 1'b0;
    logic         RESET   = 1'b1;
    logic [W-1:0] i_word  = '0;
    logic [A-1:0] i_addr  = '0;
    logic         i_last  = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready, o_SC_CLK, o_SC_EN, o_scanIn, o_busy, o_done;

    scan_loader #(
        .SRAM_WORD_LENGTH (W),
        .SRAM_ADDR_WIDTH  (A),
        .CLKS_PER_HALF_SC (CPH)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .i_word   (i_word),
        .i_addr   (i_addr),
        .i_last   (i_last),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_SC_CLK (o_SC_CLK),
        .o_SC_EN  (o_SC_EN),
        .o_scanIn (o_scanIn),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected frames in issue order.
    typedef struct {
        bit            last;
        logic [FL-1:0] val;
    } exp_t;
    exp_t exp_q[$];

    // Receiver state.
    logic [FL-1:0] sh         = '0;
    logic          prev_sc    = 1'b0;
    logic          last_en    = 1'b1;
    int            cyc        = 0;
    int            slot_idx   = 0;
    int            en_run     = 0;
    int            last_run   = 0;
    int            last_rise  = 0;
    int            sc_period  = 0;
    int            n_commits  = 0;
    int            commit_slot[$];
    logic [W-1:0]  mem [256];
    logic [W-1:0]  src [256];

    task automatic on_commit();
        exp_t e;
        n_commits++;
        commit_slot.push_back(slot_idx);
        check("commit_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.last) begin
                check("final_ones", 64'(sh[FL-1:1]), 64'(e.val[FL-1:1]));
            end else begin
                check("frame", 64'(sh), 64'(e.val));
                mem[sh[W+A-1:W]] = sh[W-1:0];
            end
        end
    endtask

    always @(negedge CLK) begin
        cyc++;
        if (o_SC_EN === 1'b0) begin
            en_run++;
        end else begin
            if (en_run > 0) last_run = en_run;
            en_run = 0;
        end
        if (o_SC_CLK && !prev_sc) begin
            slot_idx++;
            if (last_rise > 0) sc_period = cyc - last_rise;
            last_rise = cyc;
            if (o_SC_EN) begin
                sh      = {o_scanIn, sh[FL-1:1]};
                last_en = 1'b1;
            end else if (last_en) begin
                last_en = 1'b0;
                on_commit();
            end
        end
        prev_sc = o_SC_CLK;
    end

    // Issue one request; holds i_valid until accepted (bounded).
    task automatic send(input logic [W-1:0] w, input logic [A-1:0] a, input logic l, input bit keep);
        int   n = 0;
        exp_t e;
        i_word  = w;
        i_addr  = a;
        i_last  = l;
        i_valid = 1'b1;
        while (!o_ready && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (!o_ready) begin
            check("accept_timeout", 64'(o_ready), 64'd1);
            i_valid = 1'b0;
            return;
        end
        if (keep) begin
            e.last = l;
            e.val  = l ? '1 : {1'b1, a, w};
            exp_q.push_back(e);
        end
        @(negedge CLK);
        i_valid = 1'b0;
        check("busy_after_accept", 64'(o_busy), 64'd1);
    endtask

    task automatic wait_commits(input int target);
        int n = 0;
        while (n_commits < target && n < 4000) begin
            @(negedge CLK);
            n++;
        end
        check("commit_count_reached", 64'(n_commits >= target), 64'd1);
    endtask

    task automatic wait_sc_falls(input int k);
        int   seen = 0;
        int   n    = 0;
        logic p    = o_SC_CLK;
        while (seen < k && n < 4000) begin
            @(negedge CLK);
            n++;
            if (p && !o_SC_CLK) seen++;
            p = o_SC_CLK;
        end
        check("sc_fall_wait", 64'(seen), 64'(k));
    endtask

    // Random valid/data chatter while the loader is not ready.
    task automatic noise(input int k);
        repeat (k) begin
            if (!o_ready) begin
                i_valid = 1'($urandom_range(0, 1));
                i_word  = $urandom;
                i_addr  = A'($urandom);
                i_last  = 1'($urandom_range(0, 1));
            end else begin
                i_valid = 1'b0;
            end
            @(negedge CLK);
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int viol;
        int total;

        // Reset state.
        repeat (3) @(negedge CLK);
        check("rst_sc_clk", 64'(o_SC_CLK), 64'd0);
        check("rst_sc_en",  64'(o_SC_EN),  64'd1);
        check("rst_scanin", 64'(o_scanIn), 64'd0);
        check("rst_ready",  64'(o_ready),  64'd0);
        check("rst_busy",   64'(o_busy),   64'd0);
        check("rst_done",   64'(o_done),   64'd0);
        RESET = 1'b0;
        @(negedge CLK);
        check("ready_after_reset", 64'(o_ready), 64'd1);

        // Directed frame: word 0xFF at address 0x20.
        send(32'h0000_00FF, 8'h20, 1'b0, 1'b1);
        wait_commits(1);
        repeat (8) @(negedge CLK);
        check("commit_en_low_cycles", 64'(last_run), 64'(2 * CPH));
        check("sc_clk_period", 64'(sc_period), 64'(2 * CPH));
        check("idle_sc_en", 64'(o_SC_EN), 64'd1);
        check("idle_busy", 64'(o_busy), 64'd0);

        // Back-to-back frames with i_valid held.
        c0 = n_commits;
        send(32'h0302_0100, 8'h21, 1'b0, 1'b1);
        send(32'hFF06_0504, 8'h22, 1'b0, 1'b1);
        wait_commits(c0 + 2);
        check("b2b_commit_spacing", 64'(commit_slot[c0 + 1] - commit_slot[c0]),
              64'(DPE_params::SCAN_FRAME_LEN));

        // Reset during the address shift aborts the frame.
        repeat (10) @(negedge CLK);
        c0 = n_commits;
        send(32'hDEAD_BEEF, 8'h55, 1'b0, 1'b0);
        wait_sc_falls(W + 4);
        RESET = 1'b1;
        @(negedge CLK);
        check("abort_sc_en",   64'(o_SC_EN),  64'd1);
        check("abort_scanin",  64'(o_scanIn), 64'd0);
        check("abort_sc_clk",  64'(o_SC_CLK), 64'd0);
        check("abort_busy",    64'(o_busy),   64'd0);
        check("abort_ready",   64'(o_ready),  64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (300) @(negedge CLK);
        check("abort_no_commit", 64'(n_commits), 64'(c0));
        send(32'h1234_5678, 8'h23, 1'b0, 1'b1);
        wait_commits(c0 + 1);

        // Load addresses 0..0x30 with random words, gaps and valid chatter.
        for (int a = 0; a <= 'h30; a++) begin
            src[a] = $urandom;
            send(src[a], A'(a), 1'b0, 1'b1);
            noise($urandom_range(0, 120));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge CLK);
        end
        total = c0 + 1 + 'h31;
        wait_commits(total);
        repeat (200) @(negedge CLK);
        check("no_extra_frames", 64'(n_commits), 64'(total));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        // End-of-init frame.
        send('0, '0, 1'b1, 1'b1);
        wait_commits(total + 1);
        viol = 0;
        repeat (60) begin
            @(negedge CLK);
            if (o_SC_EN !== 1'b0 || o_scanIn !== 1'b1) viol++;
        end
        check("final_hold", 64'(viol), 64'd0);
        check("final_done",  64'(o_done),  64'd1);
        check("final_ready", 64'(o_ready), 64'd0);
        check("final_busy",  64'(o_busy),  64'd0);
        viol    = 0;
        i_valid = 1'b1;
        i_word  = 32'hA5A5_A5A5;
        repeat (40) begin
            @(negedge CLK);
            if (o_busy !== 1'b0) viol++;
        end
        i_valid = 1'b0;
        check("final_ignores_valid", 64'(viol), 64'd0);
        check("final_no_commit", 64'(n_commits), 64'(total + 1));

        for (int a = 0; a <= 'h30; a++) begin
            check($sformatf("mem_%0h", a), 64'(mem[a]), 64'(src[a]));
        end

        // Reset leaves FINAL and clears done.
        RESET = 1'b1;
        @(negedge CLK);
        check("reset_clears_done", 64'(o_done),  64'd0);
        check("reset_sc_en",       64'(o_SC_EN), 64'd1);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("ready_after_final_reset", 64'(o_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/scan_loader.md
SCAN_LOADER -- requirements
Module: scan_loader

Interface
REQ-001 Parameter SRAM_WORD_LENGTH, default 32 (package value), data bits per scan frame.
REQ-002 Parameter SRAM_ADDR_WIDTH, default package value, address bits per scan frame.
REQ-003 Parameter CLKS_PER_HALF_SC, default 2, CLK cycles per SC_CLK half-period; legal values are 1 or greater.
REQ-004 CLK  in  1  single system clock; all logic is on its rising edge.
REQ-005 RESET  in  1  reset, synchronous and active-high.
REQ-006 i_word  in  SRAM_WORD_LENGTH  SRAM word to load.
REQ-007 i_addr  in  SRAM_ADDR_WIDTH  SRAM target address.
REQ-008 i_last  in  1  frame is end-of-init; i_word and i_addr are ignored when set.
REQ-009 i_valid  in  1  request valid.
REQ-010 o_ready  out  1  loader can accept a request.
REQ-011 o_SC_CLK  out  1  scan clock to the DPE scan chain.
REQ-012 o_SC_EN  out  1  scan enable; low marks a frame commit.
REQ-013 o_scanIn  out  1  serial scan data.
REQ-014 o_busy  out  1  a frame is in progress.
REQ-015 o_done  out  1  end-of-init frame has completed; sticky until reset.

Function
REQ-016 o_SC_CLK is a registered square wave with period 2*CLKS_PER_HALF_SC CLK cycles; it toggles continuously from the first cycle after reset release.
REQ-017 A slot is one full SC_CLK period starting at a falling edge; o_scanIn and o_SC_EN change only at slot starts, so the receiver samples them on rising edges.
REQ-018 Handshake: a request is accepted in a cycle with i_valid and o_ready both high; the inputs are captured in that cycle.
REQ-019 o_ready = !o_busy && !o_done; a request with i_valid high while o_ready is low is ignored and not queued.
REQ-020 The first frame bit is driven at the first SC_CLK falling edge strictly after the acceptance cycle.
REQ-021 States: IDLE, SHIFT_DATA, SHIFT_ADDR, MARK, COMMIT, FINAL.
REQ-022 SHIFT_DATA: SRAM_WORD_LENGTH slots, i_word LSB-first, with o_SC_EN=1.
REQ-023 SHIFT_ADDR: SRAM_ADDR_WIDTH slots, i_addr LSB-first, with o_SC_EN=1.
REQ-024 MARK: one slot with o_scanIn=1 and o_SC_EN=1.
REQ-025 COMMIT: one slot with o_scanIn=1 and o_SC_EN=0; at the slot end o_SC_EN returns to 1 and the state returns to IDLE.
REQ-026 o_busy is high from the cycle after acceptance until the COMMIT slot ends.
REQ-027 A normal frame occupies exactly SRAM_WORD_LENGTH+SRAM_ADDR_WIDTH+2 slots.
REQ-028 A request accepted in the cycle o_busy falls starts at the next falling edge, giving back-to-back frames with no idle slot.
REQ-029 End-of-init frame (i_last=1): all SRAM_WORD_LENGTH+SRAM_ADDR_WIDTH shift slots drive 1.
REQ-030 End-of-init frame, continued: the next slot enters FINAL with o_scanIn=1 and o_SC_EN=0, both held permanently; o_done is set at FINAL entry and o_busy falls.
REQ-031 In IDLE, o_scanIn holds its last value and o_SC_EN=1.
REQ-032 The bit counter is a single down-counter of width $clog2(SRAM_WORD_LENGTH+SRAM_ADDR_WIDTH+2); it never wraps.

Reset
REQ-033 While RESET is high: o_SC_CLK=0, o_SC_EN=1, o_scanIn=0, o_ready=0, o_busy=0, o_done=0, state=IDLE, counters=0.
REQ-034 o_ready rises in the first cycle after RESET falls.
REQ-035 RESET asserted mid-frame aborts the frame; no COMMIT slot is emitted, and o_SC_EN is 1 in the next cycle.
REQ-036 RESET clears o_done and exits FINAL.

Structure
REQ-037 SRAM_WORD_LENGTH, SRAM_ADDR_WIDTH, a scan_state_t enum, and a SCAN_FRAME_LEN constant reside in DPE_params.
REQ-038 A single sub-module, sc_clk_gen, generates o_SC_CLK and a one-cycle falling-edge strike pulse; scan_loader advances only on that strike.

Verification
REQ-039 i_word=32'h000000FF, i_addr=8'h20, CLKS_PER_HALF_SC=2: expect o_scanIn slots 1x8, 0x24, then address bits 0,0,0,0,0,1,0,0, then marker 1; o_SC_EN low for exactly 4 CLK cycles; total 42 slots.
REQ-040 Two requests held back-to-back (addr 8'h21 word 'h03020100, addr 8'h22 word 'hFF060504): expect no gap slot between frames and two o_SC_EN low pulses exactly 42 slots apart.
REQ-041 i_last=1 with i_word=0: expect 40 slots of 1, then o_SC_EN held 0 indefinitely, o_done=1, o_ready=0, and a further i_valid ignored.
REQ-042 RESET pulsed during SHIFT_ADDR slot 3: expect no o_SC_EN low pulse, outputs at reset values, and a new frame accepted cleanly afterwards.
REQ-043 i_valid toggled while o_busy: expect the in-flight bit stream unchanged and no extra frames emitted.
REQ-044 Loopback into DPE at SC_CLK period 350 ns, loading addresses 0..'h30 and then end-of-init: expect the DPE SRAM contents to match the source words exactly.
